// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// read-latency bound and requester port indices.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int   RD_LAT_MAX = 4;
   localparam logic P0         = 1'b0;   // core load/store unit
   localparam logic P1         = 1'b1;   // DMA / debug loader

endpackage

// File: rtl/dmem_arbiter_if.sv
// Single-port data memory bus; the arbiter drives it through the master
// modport, the memory answers through the slave modport.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0] Add;
   logic [DATA_W-1:0] WriteData;
   logic              MemWrite;
   logic              MemRead;
   logic [DATA_W-1:0] ReadData;

   modport master (output Add, output WriteData, output MemWrite, output MemRead,
                   input  ReadData);
   modport slave  (input  Add, input  WriteData, input  MemWrite, input  MemRead,
                   output ReadData);
endinterface

// File: rtl/dmem_arbiter_arb2.sv
// Two-way arbiter producing a one-hot grant while enabled. With DMEM_ARB_RR_EN
// defined a tie alternates between ports; otherwise port 0 always wins a tie.
module arb2 (
`ifdef DMEM_ARB_RR_EN
   input  logic       clk,
   input  logic       rst_n,
`endif
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
   logic prio;   // port that wins the next tie

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       prio <= 1'b0;
      else if (|gnt)    prio <= gnt[0];
   end

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end
`else
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0])      gnt = 2'b01;
         else if (req[1]) gnt = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the LSU (port 0) and DMA (port 1),
// one outstanding access at a time. Tie policy selected by DMEM_ARB_RR_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1     // 1..RD_LAT_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   dmem_arbiter_if.master    mem
);

   localparam int CNT_W = $clog2(RD_LAT_MAX);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              win, we_q;
   logic [ADDR_W-1:0] add_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        arb_gnt;
   logic              take, mem_rd, mem_wr, rd_last;

   arb2 u_arb (
`ifdef DMEM_ARB_RR_EN
      .clk   (clk),
      .rst_n (rst_n),
`endif
      .req   ({req1, req0}),
      .en    (state == IDLE),
      .gnt   (arb_gnt)
   );

   assign take    = |arb_gnt;
   assign rd_last = mem_rd && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      case (state)
         IDLE: if (take) state_nxt = ACCESS;
         ACCESS: begin
            gnt0   = (win == P0);
            gnt1   = (win == P1);
            mem_wr = we_q;
            mem_rd = ~we_q;
            if (we_q)            state_nxt = IDLE;
            else if (cnt == '0)  state_nxt = RESP;
            else                 state_nxt = WAIT;
         end
         WAIT: begin
            mem_rd = 1'b1;
            if (cnt == '0) state_nxt = RESP;
         end
         RESP: begin
            rvalid0   = (win == P0);
            rvalid1   = (win == P1);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are latched only in IDLE; later req changes are ignored
   // until the FSM comes back around.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win     <= P0;
         we_q    <= 1'b0;
         add_q   <= '0;
         wdata_q <= '0;
         cnt     <= '0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         if (take) begin
            win     <= arb_gnt[1];
            we_q    <= arb_gnt[1] ? we1    : we0;
            add_q   <= arb_gnt[1] ? addr1  : addr0;
            wdata_q <= arb_gnt[1] ? wdata1 : wdata0;
            cnt     <= CNT_W'(RD_LAT - 1);
         end else if (mem_rd && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (rd_last) begin
            if (win == P1) rdata1 <= mem.ReadData;
            else           rdata0 <= mem.ReadData;
         end
      end
   end

   assign mem.Add       = add_q;
   assign mem.WriteData = wdata_q;
   assign mem.MemWrite  = mem_wr;
   assign mem.MemRead   = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A (RD_LAT=1) and B (RD_LAT=3) on behavioural
// memories, grants and read data checked against a scoreboard.
module tb_dmem_arbiter;

   typedef struct {
      logic        port;
      logic        we;
      logic [63:0] addr;
      logic [63:0] data;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req   [2][2];
   logic        we    [2][2];
   logic [63:0] addr  [2][2];
   logic [63:0] wdata [2][2];
   logic        gnt_o [2][2];
   logic        rv_o  [2][2];
   logic [63:0] rd_o  [2][2];
   int          lat   [2] = '{1, 3};
   int          nrv   [2] = '{0, 0};

   exp_t gq [2][$];
   exp_t rq [2][$];

   dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifa ();
   dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifb ();

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
      .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
      .gnt0(gnt_o[0][0]), .gnt1(gnt_o[0][1]), .rvalid0(rv_o[0][0]), .rvalid1(rv_o[0][1]),
      .rdata0(rd_o[0][0]), .rdata1(rd_o[0][1]), .mem(ifa));

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
      .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
      .gnt0(gnt_o[1][0]), .gnt1(gnt_o[1][1]), .rvalid0(rv_o[1][0]), .rvalid1(rv_o[1][1]),
      .rdata0(rd_o[1][0]), .rdata1(rd_o[1][1]), .mem(ifb));

   logic        mrd [2], mwr [2];
   logic [63:0] madd [2], mwd [2];
   assign mrd[0] = ifa.MemRead;   assign mrd[1] = ifb.MemRead;
   assign mwr[0] = ifa.MemWrite;  assign mwr[1] = ifb.MemWrite;
   assign madd[0] = ifa.Add;      assign madd[1] = ifb.Add;
   assign mwd[0] = ifa.WriteData; assign mwd[1] = ifb.WriteData;

   // Memories present data only in the last cycle of a MemRead burst.
   logic [63:0] mema [logic [63:0]];
   logic [63:0] memb [logic [63:0]];
   logic [63:0] rda = 64'hdead, rdb = 64'hdead;
   int rca = 0, rcb = 0;
   assign ifa.ReadData = rda;
   assign ifb.ReadData = rdb;

   always @(negedge clk) begin
      if (ifa.MemWrite) mema[ifa.Add] = ifa.WriteData;
      if (ifb.MemWrite) memb[ifb.Add] = ifb.WriteData;
      if (ifa.MemRead) begin
         rca = rca + 1;
         rda = (rca == lat[0] && mema.exists(ifa.Add)) ? mema[ifa.Add] : 64'hdead;
      end else begin
         rca = 0;
         rda = 64'hdead;
      end
      if (ifb.MemRead) begin
         rcb = rcb + 1;
         rdb = (rcb == lat[1] && memb.exists(ifb.Add)) ? memb[ifb.Add] : 64'hdead;
      end else begin
         rcb = 0;
         rdb = 64'hdead;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            gq[i].delete();
            rq[i].delete();
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            exp_t e;
            chk("memrw_excl",  64'(mrd[i] & mwr[i]), 64'd0);
            chk("gnt_excl",    64'(gnt_o[i][0] & gnt_o[i][1]), 64'd0);
            chk("rvalid_excl", 64'(rv_o[i][0] & rv_o[i][1]), 64'd0);
            if (gnt_o[i][0] | gnt_o[i][1]) begin
               if (gq[i].size() == 0) chk("gnt_unexpected", 64'd1, 64'd0);
               else begin
                  e = gq[i].pop_front();
                  chk("gnt_port", 64'(gnt_o[i][1]), 64'(e.port));
                  chk("gnt_add",  madd[i], e.addr);
                  chk("gnt_mwr",  64'(mwr[i]), 64'(e.we));
                  chk("gnt_mrd",  64'(mrd[i]), 64'(!e.we));
                  if (e.we) chk("gnt_wdata", mwd[i], e.data);
                  else begin
                     e.c = cyc;
                     rq[i].push_back(e);
                  end
               end
            end
            if (rv_o[i][0] | rv_o[i][1]) begin
               nrv[i]++;
               if (rq[i].size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
               else begin
                  e = rq[i].pop_front();
                  chk("rv_port",  64'(rv_o[i][1]), 64'(e.port));
                  chk("rv_data",  rd_o[i][e.port], e.data);
                  chk("rv_lat",   64'(cyc - e.c), 64'(lat[i]));
                  chk("rv_mrd",   64'(mrd[i]), 64'd0);
               end
            end
         end
      end
   end

   task automatic expect_gnt(input int i, input int p, input logic w,
                             input logic [63:0] a, input logic [63:0] d);
      exp_t e;
      e.port = p[0]; e.we = w; e.addr = a; e.data = d; e.c = 0;
      gq[i].push_back(e);
   endtask

   task automatic drive(input int i, input int p, input logic w,
                        input logic [63:0] a, input logic [63:0] d);
      req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdata[i][p] = w ? d : 64'd0;
   endtask

   task automatic wait_gnt(input int i, output int c);
      c = -1;
      repeat (30) begin
         @(negedge clk);
         if (gnt_o[i][0] | gnt_o[i][1]) begin
            c = cyc;
            return;
         end
      end
      chk("gnt_timeout", 64'd1, 64'd0);
   endtask

   task automatic xfer(input int i, input int p, input logic w,
                       input logic [63:0] a, input logic [63:0] d);
      int c;
      expect_gnt(i, p, w, a, d);
      drive(i, p, w, a, d);
      wait_gnt(i, c);
      @(posedge clk); #1 req[i][p] = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int c0, c1, rv_before;
      int tie_exp [4];
`ifdef DMEM_ARB_RR_EN
      tie_exp = '{0, 1, 0, 1};
`else
      tie_exp = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 2; i++)
         for (int p = 0; p < 2; p++) begin
            req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
         end

      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_gnt",    64'({gnt_o[i][1], gnt_o[i][0]}), 64'd0);
         chk("rst_rvalid", 64'({rv_o[i][1], rv_o[i][0]}), 64'd0);
         chk("rst_mem",    64'({mrd[i], mwr[i]}), 64'd0);
         chk("rst_add",    madd[i], 64'd0);
         chk("rst_rdata0", rd_o[i][0], 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // write then read back through the other port, RD_LAT=1
      xfer(0, 0, 1'b1, 64'haaae, 64'hefa);
      xfer(0, 1, 1'b0, 64'haaae, 64'hefa);
      chk("rdata1_hold", rd_o[0][1], 64'hefa);

      // tie held across four grants
      for (int k = 0; k < 4; k++)
         expect_gnt(0, tie_exp[k], 1'b1, tie_exp[k] == 0 ? 64'h100 : 64'h200,
                    tie_exp[k] == 0 ? 64'h11 : 64'h22);
      drive(0, 0, 1'b1, 64'h100, 64'h11);
      drive(0, 1, 1'b1, 64'h200, 64'h22);
      for (int k = 0; k < 4; k++) begin
         wait_gnt(0, c0);
         chk("tie_order", 64'(gnt_o[0][1]), 64'(tie_exp[k]));
      end
      @(posedge clk); #1 req[0][0] = 1'b0; req[0][1] = 1'b0;
      repeat (6) @(negedge clk);

      // port 1 request raised while port 0 read is in ACCESS
      expect_gnt(0, 0, 1'b0, 64'haaae, 64'hefa);
      expect_gnt(0, 1, 1'b0, 64'haaae, 64'hefa);
      drive(0, 0, 1'b0, 64'haaae, 64'h0);
      wait_gnt(0, c0);
      drive(0, 1, 1'b0, 64'haaae, 64'h0);
      @(posedge clk); #1 req[0][0] = 1'b0;
      wait_gnt(0, c1);
      chk("busy_gnt1", 64'(gnt_o[0][1]), 64'd1);
      chk("busy_gap",  64'(c1 - c0), 64'(lat[0] + 2));
      @(posedge clk); #1 req[0][1] = 1'b0;
      repeat (6) @(negedge clk);

      // RD_LAT=3 read of a preloaded word
      xfer(1, 1, 1'b1, 64'haf, 64'h123);
      expect_gnt(1, 0, 1'b0, 64'haf, 64'h123);
      drive(1, 0, 1'b0, 64'haf, 64'h0);
      wait_gnt(1, c0);
      chk("lat3_mrd0", 64'(mrd[1]), 64'd1);
      @(posedge clk); #1 req[1][0] = 1'b0;
      @(negedge clk); chk("lat3_mrd1", 64'(mrd[1]), 64'd1);
      @(negedge clk); chk("lat3_mrd2", 64'(mrd[1]), 64'd1);
      @(negedge clk);
      chk("lat3_mrd3",  64'(mrd[1]), 64'd0);
      chk("lat3_rv",    64'(rv_o[1][0]), 64'd1);
      chk("lat3_rdata", rd_o[1][0], 64'h123);
      repeat (4) @(negedge clk);

      // reset in the middle of a RD_LAT=3 read
      rv_before = nrv[1];
      expect_gnt(1, 0, 1'b0, 64'hbee, 64'h0);
      drive(1, 0, 1'b0, 64'hbee, 64'h0);
      wait_gnt(1, c0);
      @(posedge clk); #1 req[1][0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mrd",    64'({mrd[1], mwr[1]}), 64'd0);
      chk("arst_gnt",    64'({gnt_o[1][1], gnt_o[1][0]}), 64'd0);
      chk("arst_rvalid", 64'({rv_o[1][1], rv_o[1][0]}), 64'd0);
      chk("arst_add",    madd[1], 64'd0);
      chk("arst_wdata",  mwd[1], 64'd0);
      chk("arst_rdata0", rd_o[1][0], 64'd0);
      chk("arst_rdata1", rd_o[1][1], 64'd0);
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("arst_no_rvalid", 64'(nrv[1] - rv_before), 64'd0);

      for (int i = 0; i < 2; i++) begin
         chk("gq_drained", 64'(gq[i].size()), 64'd0);
         chk("rq_drained", 64'(rq[i].size()), 64'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
